// File: rtl/oc8051_disp_pkg.sv
// Shared constants for the two-digit seven-segment display driver.
// Segment patterns are active-low with bit 0 = a through bit 6 = g.
package oc8051_disp_pkg;

  localparam int unsigned DIGIT_W = 7;

  localparam logic [DIGIT_W-1:0] SEG_0 = 7'h40;
  localparam logic [DIGIT_W-1:0] SEG_1 = 7'h79;
  localparam logic [DIGIT_W-1:0] SEG_2 = 7'h24;
  localparam logic [DIGIT_W-1:0] SEG_3 = 7'h30;
  localparam logic [DIGIT_W-1:0] SEG_4 = 7'h19;
  localparam logic [DIGIT_W-1:0] SEG_5 = 7'h12;
  localparam logic [DIGIT_W-1:0] SEG_6 = 7'h02;
  localparam logic [DIGIT_W-1:0] SEG_7 = 7'h78;
  localparam logic [DIGIT_W-1:0] SEG_8 = 7'h00;
  localparam logic [DIGIT_W-1:0] SEG_9 = 7'h10;
  localparam logic [DIGIT_W-1:0] SEG_A = 7'h08;
  localparam logic [DIGIT_W-1:0] SEG_B = 7'h03;
  localparam logic [DIGIT_W-1:0] SEG_C = 7'h46;
  localparam logic [DIGIT_W-1:0] SEG_D = 7'h21;
  localparam logic [DIGIT_W-1:0] SEG_E = 7'h06;
  localparam logic [DIGIT_W-1:0] SEG_F = 7'h0E;

  localparam logic [DIGIT_W-1:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/oc8051_seg7_dec.sv
// Combinational hex nibble to active-low seven-segment decoder
// (letters shown as A b C d E F).
module oc8051_seg7_dec
  import oc8051_disp_pkg::*;
(
  input  logic [3:0]         nibble_i,
  output logic [DIGIT_W-1:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/oc8051_disp.sv
// Registered two-digit hex display driver: high nibble on out[13:7],
// low nibble on out[6:0], active-low segments, blank forces all off.
module oc8051_disp
  import oc8051_disp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in,
  input  logic                 blank,
  output logic [2*DIGIT_W-1:0] out
);

  logic [DIGIT_W-1:0]   seg_w [2];
  logic [2*DIGIT_W-1:0] out_d;
  logic [2*DIGIT_W-1:0] out_q;

  // Digit 0 is the low nibble, digit 1 the high nibble.
  for (genvar gi = 0; gi < 2; gi++) begin : g_digit
    oc8051_seg7_dec u_dec (
      .nibble_i (in[gi*4 +: 4]),
      .seg_o    (seg_w[gi])
    );
  end

  always_comb begin
    out_d = {seg_w[1], seg_w[0]};
    if (blank) begin
      out_d = {SEG_OFF, SEG_OFF};
    end
  end

  // Reset clears to all segments off so the display is dark during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= {SEG_OFF, SEG_OFF};
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_oc8051_disp.sv
// Self-checking bench for oc8051_disp: directed cases, exhaustive sweep,
// random stimulus with blank, and asynchronous reset pulses.
module tb_oc8051_disp;

  logic        clk;
  logic        rst;
  logic [7:0]  in;
  logic        blank;
  logic [13:0] out;

  int n_checks;
  int n_pass;

  oc8051_disp dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .blank (blank),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lit segments of each glyph, by segment letter.
  string shapes [16] = '{"abcdef", "bc", "abdeg", "abcdg",
                         "bcfg", "acdfg", "acdefg", "abc",
                         "abcdefg", "abcdfg", "abcefg", "cdefg",
                         "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] glyph(input int digit);
    logic [6:0] pat;
    string      s;
    int         idx;
    pat = 7'h7F;
    s   = shapes[digit];
    for (int k = 0; k < s.len(); k++) begin
      idx = int'(s[k]) - int'("a");
      pat[idx] = 1'b0;
    end
    return pat;
  endfunction

  function automatic logic [13:0] expect_out(input logic [7:0] v, input logic b);
    if (b) return 14'h3FFF;
    return {glyph(int'(v[7:4])), glyph(int'(v[3:0]))};
  endfunction

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: out=%h expected=%h (in=%h blank=%b)", tag, got, exp, in, blank);
    end
  endtask

  // Apply inputs after a falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input string tag, input logic [7:0] v, input logic b);
    @(negedge clk);
    in    = v;
    blank = b;
    @(posedge clk);
    #1;
    check(tag, out, expect_out(v, b));
    $display("%s in=%h blank=%b out=%h", tag, v, b, out);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst   = 1'b1;
    in    = 8'h12;
    blank = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b0;
    #1 check("rst_async", out, 14'h3FFF);
    @(posedge clk);
    #1 check("rst_hold", out, 14'h3FFF);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check("rst_release", out, 14'h3CA4);

    // Directed values.
    step("zero", 8'h00, 1'b0);
    check("zero_const", out, 14'h2040);
    step("b0", 8'hB0, 1'b0);
    check("b0_const", out, 14'h01C0);
    step("1f", 8'h1F, 1'b0);
    check("1f_const", out, 14'h3C8E);
    step("88", 8'h88, 1'b0);
    check("88_const", out, 14'h0000);

    // Blank then release.
    step("blank_on", 8'h00, 1'b1);
    check("blank_const", out, 14'h3FFF);
    step("blank_off", 8'h00, 1'b0);
    check("unblank_const", out, 14'h2040);

    // Exhaustive sweep with an asynchronous reset pulse mid-stream.
    for (int v = 0; v < 256; v++) begin
      step("sweep", 8'(v), 1'b0);
      if (v == 100) begin
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_mid", out, 14'h3FFF);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 check("rst_mid_rel", out, expect_out(in, blank));
      end
    end

    // Random input and blank.
    for (int i = 0; i < 300; i++) begin
      step("rand", 8'($urandom_range(255)), ($urandom_range(3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
